ring_buffer_flow_ctrl: RTL and testbench

Multi-channel DMA ring-buffer flow controller. Tracks producer/consumer pointer pairs for NUM_CH circular sample buffers in DDR with per-channel lap bits and computes exact fill level. Emits per-channel producer/consumer enables against programmable chunk thresholds, plus sticky overflow/underflow/range errors. Sits between the AXIS-to-RAM writers/readers and the PS register bank.

---
 rtl/ring_buffer_flow_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ring_buffer_flow_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_buffer_flow_ctrl.sv
// ring_buffer_flow_ctrl
// Flow controller for NUM_CH circular DMA sample buffers in DDR. Each channel
// tracks its producer/consumer pointers with a lap bit each, so that the fill
// level is exact, including full and empty. The block produces registered
// producer/consumer enables against programmable chunk thresholds, plus
// sticky range/overflow/underflow errors that halt the channel.
//
// Ports:
//   aclk, aresetn     clock, asynchronous active-low reset
//   dma_enable        global run enable
//   buf_size          ring size in samples (2 .. 2^ADDR_WIDTH), shared by all channels
//   prod_chunk        free space needed to raise prod_en
//   cons_chunk        fill needed to raise cons_en
//   prod_ptr/cons_ptr packed pointers, channel k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   clear_err         per-channel re-arm pulse
//   prod_en/cons_en   per-channel chunk enables
//   overflow/underflow/range_err  sticky per-channel errors
//   stopped           channel halted on an error
//   irq               registered OR of all sticky flags
//   fill_level        registered per-channel fill (RING_FLOW_FILL_STATUS_EN only)
//
// Optional feature macro: RING_FLOW_FILL_STATUS_EN adds the fill_level output.
// Limitation: a pointer that moves buf_size or more in a single cycle cannot
// be told apart from a smaller move, so such jumps go undetected.
module ring_buffer_flow_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int FILL_WIDTH = ADDR_WIDTH + 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         dma_enable,
  input  logic [FILL_WIDTH-1:0]        buf_size,
  input  logic [ADDR_WIDTH-1:0]        prod_chunk,
  input  logic [ADDR_WIDTH-1:0]        cons_chunk,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] prod_ptr,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] cons_ptr,
  input  logic [NUM_CH-1:0]            clear_err,
  output logic [NUM_CH-1:0]            prod_en,
  output logic [NUM_CH-1:0]            cons_en,
  output logic [NUM_CH-1:0]            overflow,
  output logic [NUM_CH-1:0]            underflow,
  output logic [NUM_CH-1:0]            range_err,
  output logic [NUM_CH-1:0]            stopped,
`ifdef RING_FLOW_FILL_STATUS_EN
  output logic [NUM_CH*FILL_WIDTH-1:0] fill_level,
`endif
  output logic                         irq
);

  logic [ADDR_WIDTH-1:0] prev_prod_q [NUM_CH];
  logic [ADDR_WIDTH-1:0] prev_cons_q [NUM_CH];
  logic [NUM_CH-1:0]     lap_p_q, lap_c_q, lap_p_d, lap_c_d;
  logic [NUM_CH-1:0]     prod_en_q, cons_en_q, prod_en_d, cons_en_d;
  logic [NUM_CH-1:0]     ovf_q, udf_q, rng_q, ovf_d, udf_d, rng_d;
  logic [NUM_CH-1:0]     stopped_q;
  logic                  irq_q;
`ifdef RING_FLOW_FILL_STATUS_EN
  logic [FILL_WIDTH-1:0] fill_q [NUM_CH];
  logic [FILL_WIDTH-1:0] fill_d [NUM_CH];
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [ADDR_WIDTH-1:0] pp, cp;
    logic                  laps_eq;
    logic [FILL_WIDTH:0]   bs_x, fill_x, free_x;

    assign pp = prod_ptr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign cp = cons_ptr[k*ADDR_WIDTH +: ADDR_WIDTH];

    // A pointer that went backwards has wrapped past the end of the ring.
    assign lap_p_d[k] = lap_p_q[k] ^ (pp < prev_prod_q[k]);
    assign lap_c_d[k] = lap_c_q[k] ^ (cp < prev_cons_q[k]);
    assign laps_eq    = (lap_p_d[k] == lap_c_d[k]);

    // One extra bit of headroom so illegal pointer combinations cannot alias
    // into a plausible fill before the error checks reject them.
    assign bs_x   = {1'b0, buf_size};
    assign fill_x = laps_eq ? ({2'b00, pp} - {2'b00, cp})
                            : (bs_x - {2'b00, cp} + {2'b00, pp});
    assign free_x = bs_x - fill_x;

    assign rng_d[k] = ({1'b0, pp} >= buf_size) || ({1'b0, cp} >= buf_size);
    assign ovf_d[k] = !laps_eq && (pp > cp);
    assign udf_d[k] =  laps_eq && (cp > pp);

    assign prod_en_d[k] = (free_x >= {2'b00, prod_chunk});
    assign cons_en_d[k] = (fill_x >= {2'b00, cons_chunk});
`ifdef RING_FLOW_FILL_STATUS_EN
    assign fill_d[k] = fill_x[FILL_WIDTH-1:0];
    assign fill_level[k*FILL_WIDTH +: FILL_WIDTH] = fill_q[k];
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NUM_CH; k++) begin
        prev_prod_q[k] <= '0;
        prev_cons_q[k] <= '0;
`ifdef RING_FLOW_FILL_STATUS_EN
        fill_q[k]      <= '0;
`endif
      end
      lap_p_q   <= '0;
      lap_c_q   <= '0;
      prod_en_q <= '0;
      cons_en_q <= '0;
      ovf_q     <= '0;
      udf_q     <= '0;
      rng_q     <= '0;
      stopped_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (clear_err[k]) begin
          // Re-arm wins over anything seen this cycle; the channel restarts
          // from a clean zero-pointer state on the following cycle.
          prev_prod_q[k] <= '0;
          prev_cons_q[k] <= '0;
          lap_p_q[k]     <= 1'b0;
          lap_c_q[k]     <= 1'b0;
          ovf_q[k]       <= 1'b0;
          udf_q[k]       <= 1'b0;
          rng_q[k]       <= 1'b0;
          stopped_q[k]   <= 1'b0;
          prod_en_q[k]   <= 1'b0;
          cons_en_q[k]   <= 1'b0;
`ifdef RING_FLOW_FILL_STATUS_EN
          fill_q[k]      <= '0;
`endif
        end else if (dma_enable && !stopped_q[k]) begin
          prev_prod_q[k] <= prod_ptr[k*ADDR_WIDTH +: ADDR_WIDTH];
          prev_cons_q[k] <= cons_ptr[k*ADDR_WIDTH +: ADDR_WIDTH];
          lap_p_q[k]     <= lap_p_d[k];
          lap_c_q[k]     <= lap_c_d[k];
          if (rng_d[k] || ovf_d[k] || udf_d[k]) begin
            // Only the highest-priority cause is flagged for one event.
            if (rng_d[k])      rng_q[k] <= 1'b1;
            else if (ovf_d[k]) ovf_q[k] <= 1'b1;
            else               udf_q[k] <= 1'b1;
            stopped_q[k] <= 1'b1;
            prod_en_q[k] <= 1'b0;
            cons_en_q[k] <= 1'b0;
          end else begin
            prod_en_q[k] <= prod_en_d[k];
            cons_en_q[k] <= cons_en_d[k];
`ifdef RING_FLOW_FILL_STATUS_EN
            fill_q[k]    <= fill_d[k];
`endif
          end
        end else begin
          prod_en_q[k] <= 1'b0;
          cons_en_q[k] <= 1'b0;
        end
      end
      irq_q <= |{ovf_q, udf_q, rng_q};
    end
  end

  assign prod_en   = prod_en_q;
  assign cons_en   = cons_en_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign range_err = rng_q;
  assign stopped   = stopped_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_ring_buffer_flow_ctrl.sv
module tb_ring_buffer_flow_ctrl;
  localparam int NCH = 2;
  localparam int AW  = 8;
  localparam int FW  = AW + 1;

  localparam int S_PE = 0, S_CE = 1, S_OVF = 2, S_UDF = 3, S_RNG = 4,
                 S_STP = 5, S_IRQ = 6, S_F0 = 7, S_F1 = 8;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              dma_enable;
  logic [FW-1:0]     buf_size;
  logic [AW-1:0]     prod_chunk, cons_chunk;
  logic [NCH*AW-1:0] prod_ptr, cons_ptr;
  logic [NCH-1:0]    clear_err;
  logic [NCH-1:0]    prod_en, cons_en, overflow, underflow, range_err, stopped;
  logic              irq;
`ifdef RING_FLOW_FILL_STATUS_EN
  logic [NCH*FW-1:0] fill_level;
`endif

  ring_buffer_flow_ctrl #(.NUM_CH(NCH), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn), .dma_enable(dma_enable), .buf_size(buf_size),
    .prod_chunk(prod_chunk), .cons_chunk(cons_chunk), .prod_ptr(prod_ptr),
    .cons_ptr(cons_ptr), .clear_err(clear_err), .prod_en(prod_en), .cons_en(cons_en),
    .overflow(overflow), .underflow(underflow), .range_err(range_err),
    .stopped(stopped),
`ifdef RING_FLOW_FILL_STATUS_EN
    .fill_level(fill_level),
`endif
    .irq(irq));

  always #5 aclk = ~aclk;

  typedef struct {
    int          tgt;
    int          sel;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic string nm(input int sel);
    case (sel)
      S_PE:    return "prod_en";
      S_CE:    return "cons_en";
      S_OVF:   return "overflow";
      S_UDF:   return "underflow";
      S_RNG:   return "range_err";
      S_STP:   return "stopped";
      S_IRQ:   return "irq";
      S_F0:    return "fill_level0";
      default: return "fill_level1";
    endcase
  endfunction

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      S_PE:  return 32'(prod_en);
      S_CE:  return 32'(cons_en);
      S_OVF: return 32'(overflow);
      S_UDF: return 32'(underflow);
      S_RNG: return 32'(range_err);
      S_STP: return 32'(stopped);
      S_IRQ: return 32'(irq);
`ifdef RING_FLOW_FILL_STATUS_EN
      S_F0:  return 32'(fill_level[FW-1:0]);
      S_F1:  return 32'(fill_level[2*FW-1:FW]);
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Expectation due d rising edges after the current (negedge) drive point.
  task automatic ex(input int sel, input logic [31:0] v, input int d = 1);
    exp_t e;
    e.tgt = cyc + d;
    e.sel = sel;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic ex_fill(input int ch, input logic [31:0] v);
`ifdef RING_FLOW_FILL_STATUS_EN
    ex(ch == 0 ? S_F0 : S_F1, v);
`endif
  endtask

  task automatic ptrs(input logic [AW-1:0] p0, c0, p1, c1);
    prod_ptr = {p1, p0};
    cons_ptr = {c1, c0};
  endtask

  // Monitor: pops every expectation due at this edge and compares it.
  always @(posedge aclk) begin
    logic [31:0] act;
    #1;
    cyc++;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].tgt <= cyc) begin
        act = sample(q[i].sel);
        n_checks++;
        if (act !== q[i].v || q[i].tgt != cyc) begin
          n_fail++;
          $display("FAIL %s cyc=%0d actual=%h expected=%h", nm(q[i].sel), cyc, act, q[i].v);
        end
        q.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0; dma_enable = 1'b0; buf_size = 9'd256;
    prod_chunk = 8'd16; cons_chunk = 8'd16; clear_err = '0;
    ptrs(0, 0, 0, 0);

    @(negedge aclk);
    ex(S_PE, 0); ex(S_CE, 0); ex(S_OVF, 0); ex(S_STP, 0); ex(S_IRQ, 0);

    // Release, all pointers zero: empty rings.
    @(negedge aclk); aresetn = 1'b1; dma_enable = 1'b1;
    ex(S_PE, 2'b11); ex(S_CE, 2'b00); ex(S_OVF, 0); ex(S_UDF, 0); ex(S_RNG, 0);
    ex(S_STP, 0); ex_fill(0, 0); ex(S_IRQ, 0, 2);

    @(negedge aclk); ptrs(32, 0, 0, 0);
    ex(S_PE, 2'b11); ex(S_CE, 2'b01); ex_fill(0, 32); ex_fill(1, 0);

    @(negedge aclk); ptrs(250, 20, 0, 0);
    ex(S_PE, 2'b11); ex(S_CE, 2'b01); ex_fill(0, 230);

    // Producer wraps: fill 256-20+4.
    @(negedge aclk); ptrs(4, 20, 0, 0);
    ex(S_PE, 2'b11); ex(S_CE, 2'b01); ex(S_OVF, 0); ex_fill(0, 240);

    @(negedge aclk); ptrs(12, 20, 0, 0);
    ex(S_PE, 2'b10); ex(S_CE, 2'b01); ex_fill(0, 248);

    // Exactly full is legal.
    @(negedge aclk); ptrs(20, 20, 0, 0);
    ex(S_PE, 2'b10); ex(S_CE, 2'b01); ex(S_OVF, 0); ex(S_STP, 0); ex_fill(0, 256);

    // One past full: overflow on ch0, ch1 keeps running.
    @(negedge aclk); ptrs(21, 20, 0, 0);
    ex(S_OVF, 2'b01); ex(S_STP, 2'b01); ex(S_PE, 2'b10); ex(S_CE, 2'b00);
    ex(S_UDF, 0); ex(S_RNG, 0); ex(S_IRQ, 0); ex(S_IRQ, 1, 2);

    @(negedge aclk); ptrs(21, 20, 10, 8);
    ex(S_PE, 2'b10); ex(S_CE, 2'b00); ex(S_OVF, 2'b01); ex(S_UDF, 0); ex_fill(1, 2);

    // Consumer passes producer on ch1.
    @(negedge aclk); ptrs(21, 20, 10, 12);
    ex(S_UDF, 2'b10); ex(S_STP, 2'b11); ex(S_PE, 2'b00); ex(S_CE, 2'b00); ex(S_OVF, 2'b01);

    @(negedge aclk); ptrs(21, 20, 0, 0); clear_err = 2'b10;
    ex(S_UDF, 0); ex(S_STP, 2'b01); ex(S_OVF, 2'b01); ex(S_PE, 2'b00); ex_fill(1, 0);

    // Empty with cons_chunk=0 still grants the consumer.
    @(negedge aclk); clear_err = '0; cons_chunk = 8'd0;
    ex(S_PE, 2'b10); ex(S_CE, 2'b10); ex(S_IRQ, 1);

    @(negedge aclk); cons_chunk = 8'd16;
    ex(S_PE, 2'b10); ex(S_CE, 2'b00);

    @(negedge aclk); ptrs(0, 0, 0, 0); clear_err = 2'b01;
    ex(S_OVF, 0); ex(S_STP, 0); ex(S_PE, 2'b10); ex(S_CE, 0); ex(S_IRQ, 0, 2);

    // Pointer beyond a smaller ring: range error only.
    @(negedge aclk); clear_err = '0; buf_size = 9'd200; ptrs(210, 0, 0, 0);
    ex(S_RNG, 2'b01); ex(S_OVF, 0); ex(S_UDF, 0); ex(S_STP, 2'b01);
    ex(S_PE, 2'b10); ex(S_CE, 0); ex(S_IRQ, 1, 2);

    @(negedge aclk); buf_size = 9'd256; ptrs(210, 0, 40, 0);
    ex(S_PE, 2'b10); ex(S_CE, 2'b10); ex(S_RNG, 2'b01); ex_fill(1, 40);

    // Disabled: pointer motion must be ignored, prev values held.
    @(negedge aclk); dma_enable = 1'b0; ptrs(210, 0, 250, 0);
    ex(S_PE, 0); ex(S_CE, 0); ex(S_RNG, 2'b01); ex(S_STP, 2'b01); ex_fill(1, 40);

    @(negedge aclk); dma_enable = 1'b1; ptrs(210, 0, 45, 20);
    ex(S_PE, 2'b10); ex(S_CE, 2'b10); ex(S_OVF, 0); ex(S_STP, 2'b01); ex_fill(1, 25);

    // Asynchronous reset mid-run.
    @(negedge aclk); aresetn = 1'b0;
    ex(S_PE, 0); ex(S_CE, 0); ex(S_RNG, 0); ex(S_STP, 0); ex(S_IRQ, 0);

    @(negedge aclk); aresetn = 1'b1; ptrs(0, 0, 0, 0);
    ex(S_PE, 2'b11); ex(S_CE, 0); ex(S_RNG, 0); ex(S_STP, 0); ex_fill(1, 0);

    repeat (4) @(negedge aclk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations actual=%0d expected=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
